// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// INIT(i) is the value reset and the clear sweep store into entry i.
package rf_pkg;

    typedef enum logic [1:0] {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_e;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_ADDR_W_DEF = 5;
    localparam int RF_INIT_W     = 64;

    // mode=1: entry index, zero-extended; callers truncate/extend to DATA_W.
    function automatic logic [RF_INIT_W-1:0] rf_init(input logic [31:0] idx, input logic mode);
        return mode ? {32'd0, idx} : '0;
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: on request, walks every entry address once, one per cycle,
// then pulses clr_done. Holds busy through the sweep and the done cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RF_IDLE  | no sweep; clr_req starts one
//   RF_CLEAR | writes INIT into entry cnt each cycle, cnt = 0 .. DEPTH-1
//   RF_DONE  | one-cycle clr_done pulse; clr_req ignored
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we   = 1'b0;
        busy     = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            RF_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                // Stop on the last entry rather than wrapping the counter.
                if (cnt_q == CNT_LAST) begin
                    state_d = RF_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            RF_DONE: begin
                busy     = 1'b1;
                clr_done = 1'b1;
                state_d  = RF_IDLE;
            end
            default: state_d = RF_IDLE;
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_multi.sv
// Parametrised 2R/1W register file with optional write bypass and a clear sweep.
// Define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_multi
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = RF_ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int CLR_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] probe,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit BYP   = (BYPASS != 0);

    function automatic logic [DATA_W-1:0] init_val(input logic [31:0] idx);
`ifdef RF_ZERO_REG_EN
        if (idx == 32'd0) return '0;
`endif
        return DATA_W'(rf_init(idx, CLR_MODE != 0));
    endfunction

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_zero;
    logic              wr_acc;

    rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy),
        .clr_done (clr_done)
    );

`ifdef RF_ZERO_REG_EN
    assign wr_zero = (A3 == '0);
`else
    assign wr_zero = 1'b0;
`endif

    // Writes to a hardwired entry vanish silently: neither accepted nor dropped.
    assign wr_acc  = WE3 && !busy && rst && !wr_zero;
    assign wr_drop = WE3 && busy && !wr_zero;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= init_val(32'(i));
            end
        end else if (clr_we) begin
            regs_q[clr_addr] <= init_val(32'(clr_addr));
        end else if (wr_acc) begin
            regs_q[A3] <= WD3;
        end
    end

    always_comb begin
        RD1   = regs_q[A1];
        RD2   = regs_q[A2];
        probe = regs_q[A3];
        if (BYP && wr_acc && (A1 == A3)) RD1 = WD3;
        if (BYP && wr_acc && (A2 == A3)) RD2 = WD3;
`ifdef RF_ZERO_REG_EN
        if (A1 == '0) RD1 = '0;
        if (A2 == '0) RD2 = '0;
        if (A3 == '0) probe = '0;
`endif
    end

endmodule

// File: tb/tb_regfile_multi.sv
// Directed bench: dut_a (BYPASS=1, CLR_MODE=1) and dut_b (BYPASS=0, CLR_MODE=0)
// share all inputs; expectations are hand-derived per instance.
module tb_regfile_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3, clr_req;

    logic [31:0] rd1_a, rd2_a, probe_a, rd1_b, rd2_b, probe_b;
    logic        busy_a, done_a, drop_a, busy_b, done_b, drop_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_multi #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CLR_MODE(1)) dut_a (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(rd1_a), .RD2(rd2_a), .probe(probe_a), .clr_req(clr_req),
        .busy(busy_a), .clr_done(done_a), .wr_drop(drop_a)
    );

    regfile_multi #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CLR_MODE(0)) dut_b (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3), .WE3(WE3),
        .RD1(rd1_b), .RD2(rd2_b), .probe(probe_b), .clr_req(clr_req),
        .busy(busy_b), .clr_done(done_b), .wr_drop(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_init(input string tag);
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            settle();
            chk({tag, "_a_rd1"}, rd1_a, 32'(i));
            chk({tag, "_a_rd2"}, rd2_a, 32'(31 - i));
            chk({tag, "_b_rd1"}, rd1_b, 32'd0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0; WE3 = 1'b0; clr_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        settle();
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_drop_a", 32'(drop_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        check_all_init("rst");

        // Write 5 <= DEADBEEF: bypassed on dut_a only; probe never bypassed.
        A1 = 5'd5; A2 = 5'd5; A3 = 5'd5; WD3 = 32'hDEADBEEF; WE3 = 1'b1;
        settle();
        chk("byp_a_rd1", rd1_a, 32'hDEADBEEF);
        chk("byp_a_rd2", rd2_a, 32'hDEADBEEF);
        chk("byp_a_probe", probe_a, 32'd5);
        chk("nobyp_b_rd1", rd1_b, 32'd0);
        chk("nobyp_b_drop", 32'(drop_b), 32'd0);
        tick();
        WE3 = 1'b0;
        settle();
        chk("wr5_a_rd1", rd1_a, 32'hDEADBEEF);
        chk("wr5_b_rd1", rd1_b, 32'hDEADBEEF);
        chk("wr5_b_probe", probe_b, 32'hDEADBEEF);

        // Write 3 <= FF, then read back.
        A3 = 5'd3; WD3 = 32'hFF; WE3 = 1'b1; A2 = 5'd3;
        settle();
        chk("wr3_b_rd2_old", rd2_b, 32'd0);
        tick();
        WE3 = 1'b0; A1 = 5'd3;
        settle();
        chk("wr3_a_rd1", rd1_a, 32'hFF);
        chk("wr3_b_rd1", rd1_b, 32'hFF);

        // Full sweep; busy for 33 cycles, clr_done on the 33rd.
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int n = 1; n <= 33; n++) begin
            WE3 = 1'b0; clr_req = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0;
            if (n == 1) A1 = 5'd5;
            if (n == 2) A1 = 5'd3;
            if (n == 3) clr_req = 1'b1;
            if (n == 5) begin A3 = 5'd10; WD3 = 32'd1234; WE3 = 1'b1; A1 = 5'd10; end
            if (n == 10) A1 = 5'd5;
            if (n == 33) clr_req = 1'b1;
            settle();
            chk($sformatf("sw%0d_busy_a", n), 32'(busy_a), 32'd1);
            chk($sformatf("sw%0d_busy_b", n), 32'(busy_b), 32'd1);
            chk($sformatf("sw%0d_done_a", n), 32'(done_a), (n == 33) ? 32'd1 : 32'd0);
            if (n == 1) begin
                chk("sw1_a_rd5", rd1_a, 32'hDEADBEEF);
                chk("sw1_b_rd5", rd1_b, 32'hDEADBEEF);
            end
            if (n == 2) begin
                chk("sw2_a_rd3", rd1_a, 32'hFF);
                chk("sw2_b_rd3", rd1_b, 32'hFF);
            end
            if (n == 5) begin
                chk("sw5_drop_a", 32'(drop_a), 32'd1);
                chk("sw5_drop_b", 32'(drop_b), 32'd1);
                chk("sw5_a_nobyp", rd1_a, 32'd10);
                chk("sw5_b_nobyp", rd1_b, 32'd0);
            end
            if (n == 10) begin
                chk("sw10_a_rd5", rd1_a, 32'd5);
                chk("sw10_b_rd5", rd1_b, 32'd0);
            end
            tick();
        end
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("post_sw_busy_a", 32'(busy_a), 32'd0);
            chk("post_sw_done_a", 32'(done_a), 32'd0);
            tick();
        end
        check_all_init("post_sw");

        // clr_req together with an accepted write: write lands, sweep overwrites it.
        A1 = 5'd7; A3 = 5'd7; WD3 = 32'h77; WE3 = 1'b1; clr_req = 1'b1;
        settle();
        chk("sim_a_byp", rd1_a, 32'h77);
        chk("sim_a_drop", 32'(drop_a), 32'd0);
        tick();
        WE3 = 1'b0; clr_req = 1'b0;
        settle();
        chk("sim_b_rd7", rd1_b, 32'h77);
        chk("sim_busy_b", 32'(busy_b), 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done_b) seen = 1'b1;
            tick();
        end
        chk("sim_done_seen", 32'(seen), 32'd1);
        settle();
        chk("sim_a_rd7", rd1_a, 32'd7);
        chk("sim_b_rd7_clr", rd1_b, 32'd0);

        // Reset at sweep cycle 12 aborts the sweep and restores every entry.
        A3 = 5'd20; WD3 = 32'hAAAA; WE3 = 1'b1;
        tick();
        WE3 = 1'b0; A1 = 5'd20;
        settle();
        chk("wr20_a", rd1_a, 32'hAAAA);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (11) tick();
        settle();
        chk("ab_busy_pre", 32'(busy_a), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        settle();
        chk("ab_busy_a", 32'(busy_a), 32'd0);
        chk("ab_busy_b", 32'(busy_b), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_a || done_b || busy_a) seen = 1'b1;
            tick();
        end
        chk("ab_no_done", 32'(seen), 32'd0);
        check_all_init("ab");

        // Write to address 0.
        A1 = 5'd0; A3 = 5'd0; WD3 = 32'd99; WE3 = 1'b1;
        settle();
`ifdef RF_ZERO_REG_EN
        chk("z_a_rd1", rd1_a, 32'd0);
        chk("z_a_probe", probe_a, 32'd0);
        chk("z_a_drop", 32'(drop_a), 32'd0);
        tick();
        WE3 = 1'b0;
        settle();
        chk("z_a_rd1_next", rd1_a, 32'd0);
        chk("z_b_probe_next", probe_b, 32'd0);
`else
        chk("z_a_rd1", rd1_a, 32'd99);
        chk("z_a_probe", probe_a, 32'd0);
        chk("z_a_drop", 32'(drop_a), 32'd0);
        tick();
        WE3 = 1'b0;
        settle();
        chk("z_a_rd1_next", rd1_a, 32'd99);
        chk("z_b_probe_next", probe_b, 32'd99);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised successor to the Lab7 32x32 register file: configurable width and depth, two asynchronous read ports, one synchronous write port, optional write-to-read bypass.
- Adds a hardware clear sequencer that re-initialises every entry, one entry per cycle, on request.
- Sits in the single-cycle/pipelined CPU datapath between decode (addresses) and ALU/writeback.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- BYPASS, 1, 1 = a same-cycle accepted write is forwarded to a matching read port; 0 = no forwarding.
- CLR_MODE, 1, init value used by reset and the sweep; 1 = entry index (zero-extended or truncated to DATA_W), 0 = all zeros.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- A1  in  ADDR_W  read address, port 1.
- A2  in  ADDR_W  read address, port 2.
- A3  in  ADDR_W  write address; also the probe address.
- WD3  in  DATA_W  write data.
- WE3  in  1  write enable.
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- probe  out  DATA_W  stored content of entry A3 (never bypassed).
- clr_req  in  1  request a full clear sweep.
- busy  out  1  high while a sweep is in progress.
- clr_done  out  1  one-cycle pulse when a sweep completes.
- wr_drop  out  1  one-cycle pulse when a write is discarded because a sweep is in progress.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low: sampled only on the rising edge of clk; reset takes effect when rst==0.
- Reset (rst==0 at a rising edge):
  - Every entry i is loaded with INIT(i).
  - FSM goes to IDLE; sweep counter goes to 0.
  - busy, clr_done and wr_drop read 0 after that edge.
- Reads: combinational from stored contents. RD1=regs[A1], RD2=regs[A2].
- Write acceptance:
  - A write is accepted when WE3=1, the FSM is in IDLE, and rst=1.
  - An accepted write updates regs[A3] at the rising edge; the new value is visible on reads the following cycle.
- Bypass (BYPASS=1): if the write is accepted this cycle and A1==A3, RD1=WD3 in the same cycle; likewise RD2 when A2==A3.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_req=1; counter is set to 0.
  - CLEAR: each cycle writes regs[cnt] <= INIT(cnt) and increments cnt. When cnt==DEPTH-1 that entry is written and the FSM goes to DONE. A sweep takes exactly DEPTH cycles in CLEAR.
  - DONE: clr_done=1 for one cycle, then IDLE. clr_req is ignored in DONE.
  - busy=1 in CLEAR and DONE.
- Simultaneous events:
  - clr_req and an accepted write in the same IDLE cycle: the write is performed, and the sweep later overwrites it.
  - clr_req during CLEAR or DONE: ignored, with no re-queue.
  - WE3=1 while busy: the write is discarded, wr_drop=1 that cycle, and bypass is not applied.
  - Reads during a sweep return current stored contents (partially cleared).
- Reset mid-sweep: the sweep is aborted, all entries get INIT, and the FSM is in IDLE.
- Counter width is ADDR_W; it must not wrap past DEPTH-1.

Optional Feature:
- Macro: RF_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero.
  - RD1/RD2/probe read 0 whenever the address is 0.
  - Writes to address 0 are silently ignored: no wr_drop, no bypass.
  - Reset and sweep store 0 in entry 0.
- Undefined: entry 0 behaves like every other entry.

Decomposition:
- Package rf_pkg:
  - typedef enum rf_state_e {RF_IDLE, RF_CLEAR, RF_DONE}.
  - Localparams RF_DATA_W_DEF=32 and RF_ADDR_W_DEF=5.
  - Function rf_init(idx, mode) returning INIT.
- Sub-module rf_clear_seq:
  - Contains the FSM and counter.
  - Outputs: clr_we, clr_addr, busy, clr_done.
  - The top-level regfile_multi muxes between the sequencer write and the external write.

Test Plan:
- Reset, then read every entry with DATA_W=32, CLR_MODE=1 -> regs[i]==i (e.g. A1=7 -> RD1=7); busy=0, clr_done=0.
- Write WE3=1, A3=5, WD3=32'hDEADBEEF, A1=5:
  - BYPASS=1 -> RD1=DEADBEEF in the same cycle.
  - BYPASS=0 -> RD1=5 that cycle, DEADBEEF the next cycle; probe=DEADBEEF the next cycle.
- Pulse clr_req after writing regs[3]=32'hFF, CLR_MODE=0 -> busy high for DEPTH+1=33 cycles, clr_done pulse on the 33rd; then regs[3]=0 and every entry is 0.
- WE3=1, A3=10, WD3=1234 during CLEAR -> wr_drop=1 that cycle; after the sweep regs[10]=10 (CLR_MODE=1).
- Assert rst=0 at sweep cycle 12 -> next cycle busy=0, FSM IDLE, all regs[i]==i; clr_done never pulses.
- With RF_ZERO_REG_EN defined: write A3=0, WD3=99 -> RD1 (A1=0)=0, probe=0, wr_drop=0.
